fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the main decoder.
- Owns the PC register and fetches one instruction at a time from instruction memory over a request/grant/response handshake.
- Presents Instr/PC/PCPlus4 to decode and consumes PCSrc and ImmExt from the decode/execute side to select the next PC.
- Also accepts an asynchronous-to-pipeline flush/redirect, e.g. from trap or debug logic.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/pc_next_sel.sv | 39 +++
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN,
        FAULT
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC mux: flush target, branch/jump target or sequential PC, plus alignment handling.
// With FETCH_MISALIGN_TRAP_EN the raw target is passed through and flagged; otherwise it is word-aligned.
module pc_next_sel #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] flush_pc,
    input  logic            pc_src,
    input  logic            flush,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            misaligned
`endif
);

    logic [XLEN-1:0] target;

    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        if (flush) begin
            target = flush_pc;
        end else if (pc_src) begin
            target = pc + imm_ext;
        end else begin
            target = pc_plus4;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (target[1:0] != 2'b00);
    assign next_pc    = target;
`else
    assign next_pc    = target & ~XLEN'(3);
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register plus single-outstanding imem request/grant/response FSM.
// Optional misaligned-target trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            fetch_fault
`endif
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_q, instr_q, next_pc;
    logic            pc_load, instr_load, retire;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            misaligned;
`endif

    assign retire = (state == HOLD) && instr_ready;

    pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
        .pc        (pc_q),
        .imm_ext   (ImmExt),
        .flush_pc  (flush_pc),
        .pc_src    (PCSrc),
        .flush     (flush),
        .pc_plus4  (PCPlus4),
        .next_pc   (next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misaligned(misaligned)
`endif
    );

    always_comb begin
        state_next = state;
        instr_load = 1'b0;
        pc_load    = flush || retire;
        case (state)
            IDLE:  state_next = REQ;
            // A granted request that gets flushed still owes a response, so it must be drained.
            REQ:   if (imem_gnt) state_next = flush ? DRAIN : WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    if (flush) begin
                        state_next = REQ;
                    end else begin
                        instr_load = 1'b1;
                        state_next = HOLD;
                    end
                end else if (flush) begin
                    state_next = DRAIN;
                end
            end
            HOLD:  if (flush || instr_ready) state_next = REQ;
            DRAIN: if (imem_rvalid) state_next = REQ;
            FAULT: if (flush) state_next = REQ;
            default: state_next = IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (pc_load && misaligned) state_next = FAULT;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state <= state_next;
            if (pc_load)    pc_q    <= next_pc;
            if (instr_load) instr_q <= imem_rdata;
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign Instr       = instr_q;
    assign instr_valid = (state == HOLD);
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state == FAULT);
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios, then randomized traffic against a transaction-level model.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr, PC, PCPlus4;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        PCSrc = 1'b0;
    logic [31:0] ImmExt = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fetch_fault;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .Instr      (Instr),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .PCSrc      (PCSrc),
        .ImmExt     (ImmExt),
        .flush      (flush),
        .flush_pc   (flush_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_fault(fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory contents are a function of the address so a stale response is always distinguishable.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ INSTR_NOP;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects the DUT to be requesting exp_addr; completes one fetch and leaves it holding data.
    task automatic do_fetch(input string tag, input logic [31:0] exp_addr, input logic [31:0] data);
        check({tag, "_req"}, imem_req, 1);
        check({tag, "_addr"}, imem_addr, exp_addr);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        check({tag, "_wait_req"}, imem_req, 0);
        check({tag, "_wait_valid"}, instr_valid, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        check({tag, "_valid"}, instr_valid, 1);
        check({tag, "_instr"}, Instr, data);
        check({tag, "_pc"}, PC, exp_addr);
        check({tag, "_pcplus4"}, PCPlus4, exp_addr + 32'd4);
    endtask

    task automatic retire(input logic src, input logic [31:0] imm);
        instr_ready = 1'b1;
        PCSrc       = src;
        ImmExt      = imm;
        tick();
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        ImmExt      = '0;
    endtask

    task automatic redirect(input logic [31:0] target);
        flush    = 1'b1;
        flush_pc = target;
        tick();
        flush    = 1'b0;
    endtask

    logic [31:0] model_pc, pend_addr, last_data;
    logic        pending;
    int          lat, retires;

    initial begin
        // Reset and the first 3-cycle fetch
        tick();
        tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("rst_fault", fetch_fault, 0);
`endif
        rst = 1'b1;
        tick();
        do_fetch("first", 32'h0, 32'h0050_0093);
        retire(1'b0, 32'h0);
        check("first_next_valid", instr_valid, 0);
        check("first_next_addr", imem_addr, 32'h4);

        // Branch taken / not taken
        redirect(32'h40);
        do_fetch("br_t", 32'h40, INSTR_NOP);
        retire(1'b1, 32'hFFFF_FFF8);
        check("br_taken_addr", imem_addr, 32'h38);
        redirect(32'h40);
        do_fetch("br_nt", 32'h40, INSTR_NOP);
        retire(1'b0, 32'h0000_1000);
        check("br_not_taken_addr", imem_addr, 32'h44);

        // PC wrap
        redirect(32'hFFFF_FFFC);
        last_data = mem_word(32'hFFFF_FFFC);
        do_fetch("wrap", 32'hFFFF_FFFC, last_data);
        check("wrap_pcplus4", PCPlus4, 32'h0);
        retire(1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);

        // Flush while waiting, stale response arrives later and must be dropped
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        flush_pc = 32'h100;
        tick();
        flush    = 1'b0;
        check("drain_req0", imem_req, 0);
        check("drain_valid0", instr_valid, 0);
        tick();
        check("drain_req1", imem_req, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("drain_valid2", instr_valid, 0);
        check("drain_instr_held", Instr, last_data);
        do_fetch("after_drain", 32'h100, INSTR_NOP);

        // Backpressure with distracting inputs
        for (int i = 0; i < 5; i++) begin
            PCSrc       = 1'b1;
            ImmExt      = $urandom & ~32'h3;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
            tick();
            check("bp_valid", instr_valid, 1);
            check("bp_instr", Instr, INSTR_NOP);
            check("bp_pc", PC, 32'h100);
            check("bp_req", imem_req, 0);
        end
        imem_rvalid = 1'b0;
        retire(1'b0, 32'h0);
        check("bp_next_addr", imem_addr, 32'h104);

        // Reset during WAIT; late response ignored
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst      = 1'b0;
        tick();
        rst = 1'b1;
        check("wrst_req", imem_req, 0);
        check("wrst_valid", instr_valid, 0);
        check("wrst_pc", PC, 32'h0);
        check("wrst_instr", Instr, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("wrst_late_valid", instr_valid, 0);
        do_fetch("wrst_fetch", 32'h0, INSTR_NOP);
        retire(1'b0, 32'h0);

        // Misaligned branch target
        redirect(32'h40);
        do_fetch("mis", 32'h40, INSTR_NOP);
        retire(1'b1, 32'h2);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("mis_fault", fetch_fault, 1);
        check("mis_req", imem_req, 0);
        tick();
        check("mis_fault_hold", fetch_fault, 1);
        check("mis_req_hold", imem_req, 0);
        redirect(32'h80);
        check("mis_fault_clr", fetch_fault, 0);
        check("mis_resume_req", imem_req, 1);
        check("mis_resume_addr", imem_addr, 32'h80);
`else
        check("mis_aligned_addr", imem_addr, 32'h40);
        check("mis_aligned_req", imem_req, 1);
        redirect(32'h103);
        check("mis_flush_addr", imem_addr, 32'h100);
`endif
        redirect(32'h200);

        // Randomized traffic against a transaction-level model
        model_pc = 32'h200;
        pending  = 1'b0;
        pend_addr = '0;
        lat      = 0;
        retires  = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instr_valid) begin
                check("rand_instr", Instr, mem_word(model_pc));
                check("rand_pc", PC, model_pc);
                check("rand_pcplus4", PCPlus4, model_pc + 32'd4);
            end
            if (pending) check("rand_req_while_pending", imem_req, 0);

            flush       = ($urandom_range(0, 19) == 0);
            flush_pc    = $urandom & ~32'h3;
            instr_ready = ($urandom_range(0, 2) != 0);
            PCSrc       = $urandom_range(0, 1) != 0;
            ImmExt      = ($urandom_range(0, 511) << 2) - 32'd1024;
            imem_gnt    = imem_req && !pending && ($urandom_range(0, 2) != 0);
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pending) begin
                if (lat == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = 32'hBAD0_0000 ^ $urandom;
            end

            if (imem_rvalid && pending) pending = 1'b0;
            if (imem_req && imem_gnt) begin
                check("rand_addr", imem_addr, model_pc);
                pending   = 1'b1;
                pend_addr = model_pc;
                lat       = $urandom_range(0, 2);
            end
            if (flush) begin
                model_pc = flush_pc;
            end else if (instr_valid && instr_ready) begin
                retires++;
                model_pc = PCSrc ? model_pc + ImmExt : model_pc + 32'd4;
            end
            tick();
        end
        flush       = 1'b0;
        instr_ready = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        check("rand_progress", (retires > 100) ? 32'd1 : 32'd0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
